// File: rtl/lcd_pkg.sv
// Shared constants for the LCD panel reset sequencer: state encoding and default timing.
// No logic; the 50 MHz reference clock drives the default cycle counts.
// Timing defaults: 10 us minimum low pulse, 120 ms controller recovery.
package lcd_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_ASSERT  = 2'd0;
   localparam logic [1:0] ST_RECOVER = 2'd1;
   localparam logic [1:0] ST_READY   = 2'd2;

   // Reference system clock
   localparam int CLK_HZ = 50_000_000;

   // Default timing, derived from the reference clock
   localparam int T_ASSERT_CYC_DEF  = CLK_HZ / 100_000;       // 10 us  -> 500
   localparam int T_RECOVER_CYC_DEF = (CLK_HZ / 1000) * 120;  // 120 ms -> 6_000_000
   localparam int CNT_W_DEF         = 23;

   // True when a terminal count of (cycles-1) fits in a counter of the given width
   function automatic bit cnt_fits(input int cycles, input int width);
      return (longint'(cycles) - 1) < (longint'(1) << width);
   endfunction

endpackage

// File: rtl/lcd_rst_sequencer.sv
// Turns the software reset level into a timed LCD reset pulse plus recovery wait, then flags ready.
// Latency: outputs are registered and change on the same edge as the FSM state (1 cycle from rst_req).
// No backpressure: rst_req is a level that is sampled every cycle and never stalled.
module lcd_rst_sequencer
   import lcd_pkg::*;
#(
   parameter int T_ASSERT_CYC  = T_ASSERT_CYC_DEF,
   parameter int T_RECOVER_CYC = T_RECOVER_CYC_DEF,
   parameter int CNT_W         = CNT_W_DEF
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rst_req,
   output logic       lcd_rst_n,
   output logic       lcd_ready,
   output logic       busy,
   output logic [7:0] reset_count
);

   // Reject parameter sets the counter cannot represent
   if (T_ASSERT_CYC < 1 || T_RECOVER_CYC < 1) begin : g_bad_timing
      $error("lcd_rst_sequencer: timing parameters must be at least 1 cycle");
   end
   if (!cnt_fits(T_ASSERT_CYC, CNT_W) || !cnt_fits(T_RECOVER_CYC, CNT_W)) begin : g_bad_width
      $error("lcd_rst_sequencer: CNT_W too small for T_ASSERT_CYC/T_RECOVER_CYC");
   end

   localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(T_ASSERT_CYC - 1);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(T_RECOVER_CYC - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             count_inc;

   // Next-state and counter decode; a low rst_req always wins over counter expiry
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      count_inc = 1'b0;
      case (state)
         ST_ASSERT: begin
            // Counter saturates at the terminal value, so holding rst_req low never wraps it
            if (cnt == ASSERT_LAST) begin
               if (rst_req) begin
                  state_nxt = ST_RECOVER;
                  cnt_nxt   = '0;
                  count_inc = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_RECOVER: begin
            if (!rst_req) begin
               // Abort: panel goes straight back into reset, ready never raised
               state_nxt = ST_ASSERT;
               cnt_nxt   = '0;
            end else if (cnt == RECOVER_LAST) begin
               state_nxt = ST_READY;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_READY: begin
            if (!rst_req) begin
               state_nxt = ST_ASSERT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            // Unreachable encoding: recover by re-running the reset sequence
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and outputs all load from the next-state decode on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_ASSERT;
         cnt         <= '0;
         lcd_rst_n   <= 1'b0;
         lcd_ready   <= 1'b0;
         busy        <= 1'b1;
         reset_count <= 8'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lcd_rst_n <= (state_nxt != ST_ASSERT);
         lcd_ready <= (state_nxt == ST_READY);
         busy      <= (state_nxt != ST_READY);
         if (count_inc) begin
            reset_count <= reset_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_rst_sequencer.sv
// Self-checking bench for lcd_rst_sequencer with shortened timing (4-cycle pulse, 8-cycle recovery).
// Every cycle an expected output word is queued from a pulse-timing model and popped after the edge.
// Directed scenarios add pulse-width, ready-delay and pulse-count checks on top of the scoreboard.
module tb_lcd_rst_sequencer;

   localparam int TA = 4;
   localparam int TR = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       rst_req;
   logic       lcd_rst_n;
   logic       lcd_ready;
   logic       busy;
   logic [7:0] reset_count;

   lcd_rst_sequencer #(
      .T_ASSERT_CYC  (TA),
      .T_RECOVER_CYC (TR),
      .CNT_W         (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rst_req     (rst_req),
      .lcd_rst_n   (lcd_rst_n),
      .lcd_ready   (lcd_ready),
      .busy        (busy),
      .reset_count (reset_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n;
      logic       ready;
      logic       busy;
      logic [7:0] count;
   } obs_t;

   obs_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Pulse-timing reference: tracks how long the pin has been low/high, not FSM state
   int m_low      = 1;
   int m_low_len  = 0;
   int m_high_len = 0;
   int m_pulses   = 0;

   // Bench-side measurements of the DUT waveform
   logic prev_rst_n   = 1'b0;
   logic prev_ready   = 1'b0;
   int   low_run      = 0;
   int   high_run     = 0;
   int   last_low     = 0;
   int   last_delay   = 0;
   int   ready_rises  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input logic rq, input logic rs);
      if (rs) begin
         m_low = 1; m_low_len = 1; m_high_len = 0; m_pulses = 0;
      end else if (m_low != 0) begin
         if (m_low_len >= TA && rq) begin
            m_low = 0; m_high_len = 0; m_pulses = (m_pulses + 1) % 256;
         end else if (m_low_len < TA) begin
            m_low_len++;
         end
      end else begin
         if (!rq) begin
            m_low = 1; m_low_len = 1;
         end else if (m_high_len < TR) begin
            m_high_len++;
         end
      end
   endtask

   // Drive one cycle, queue the model's expectation, sample the DUT after the edge
   task automatic step(input logic rq, input logic rs);
      obs_t e;
      obs_t g;
      rst_req = rq;
      reset   = rs;
      model_edge(rq, rs);
      e.rst_n = (m_low == 0);
      e.ready = (m_low == 0) && (m_high_len >= TR);
      e.busy  = !e.ready;
      e.count = 8'(m_pulses);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      g = '{lcd_rst_n, lcd_ready, busy, reset_count};
      e = exp_q.pop_front();
      chk("sb_rst_n", g.rst_n, e.rst_n);
      chk("sb_ready", g.ready, e.ready);
      chk("sb_busy",  g.busy,  e.busy);
      chk("sb_count", g.count, e.count);
      // Waveform measurements
      if (!lcd_rst_n) begin
         low_run = prev_rst_n ? 1 : low_run + 1;
      end else if (!prev_rst_n) begin
         chk("pulse_min", low_run >= TA, 1);
         last_low = low_run;
         high_run = 0;
      end else begin
         high_run++;
      end
      if (lcd_ready && !prev_ready) begin
         last_delay = high_run;
         ready_rises++;
      end
      prev_rst_n = lcd_rst_n;
      prev_ready = lcd_ready;
   endtask

   int rises_before;

   initial begin
      reset   = 1'b1;
      rst_req = 1'b1;

      // Reset edge (edge 0) then power-on sequence
      step(1'b1, 1'b1);
      chk("rst_rst_n", lcd_rst_n, 1'b0);
      chk("rst_ready", lcd_ready, 1'b0);
      chk("rst_busy",  busy, 1'b1);
      chk("rst_count", reset_count, 8'd0);
      repeat (12) step(1'b1, 1'b0);
      chk("t1_low_len", last_low, 4);
      chk("t1_delay",   last_delay, 8);
      chk("t1_ready",   lcd_ready, 1'b1);
      chk("t1_busy",    busy, 1'b0);
      chk("t1_count",   reset_count, 8'd1);
      repeat (3) step(1'b1, 1'b0);

      // One-cycle glitch still gives a full-width pulse
      step(1'b0, 1'b0);
      chk("t2_fall_ready", lcd_ready, 1'b0);
      repeat (12) step(1'b1, 1'b0);
      chk("t2_low_len", last_low, 4);
      chk("t2_delay",   last_delay, 8);
      chk("t2_count",   reset_count, 8'd2);

      // Long request: pulse width follows rst_req
      repeat (10) step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      chk("t3_not_yet", lcd_ready, 1'b0);
      repeat (10) step(1'b1, 1'b0);
      chk("t3_low_len", last_low, 10);
      chk("t3_delay",   last_delay, 8);
      chk("t3_count",   reset_count, 8'd3);

      // Abort during recovery
      step(1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0);
      chk("t4_rise", lcd_rst_n, 1'b1);
      chk("t4_count_a", reset_count, 8'd4);
      rises_before = ready_rises;
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("t4_abort_rst_n", lcd_rst_n, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      chk("t4_count_hold", reset_count, 8'd4);
      step(1'b1, 1'b0);
      chk("t4_count_b", reset_count, 8'd5);
      chk("t4_no_ready", ready_rises, rises_before);
      repeat (8) step(1'b1, 1'b0);
      chk("t4_ready", lcd_ready, 1'b1);

      // Synchronous reset while ready
      step(1'b1, 1'b1);
      chk("t5_rst_n",  lcd_rst_n, 1'b0);
      chk("t5_ready",  lcd_ready, 1'b0);
      chk("t5_count",  reset_count, 8'd0);
      repeat (12) step(1'b1, 1'b0);
      chk("t5_low_len", last_low, 4);
      chk("t5_delay",   last_delay, 8);
      chk("t5_count1",  reset_count, 8'd1);

      // Pulse counter wrap
      for (int p = 0; p < 255; p++) begin
         step(1'b0, 1'b0);
         repeat (4) step(1'b1, 1'b0);
      end
      chk("t6_wrap", reset_count, 8'd0);
      step(1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0);
      chk("t6_after_wrap", reset_count, 8'd1);
      repeat (9) step(1'b1, 1'b0);
      chk("t6_ready", lcd_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
